// File: rtl/des_round_ctrl_if.sv
// Host-side handshake bundle for the DES round sequencer: block accept and result delivery.
interface des_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic in_decrypt;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output in_decrypt,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_decrypt,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES sequencer: steps one shared round datapath and the C/D key shifter
// through load, NUM_ROUNDS Feistel rounds and the final permutation, one block at a time.
module des_round_ctrl #(
  parameter int unsigned              NUM_ROUNDS  = 16,
  parameter logic [NUM_ROUNDS-1:0]    SHIFT_SCHED = 16'b1000_0001_0000_0011
) (
  input  logic                   clk,
  input  logic                   rst_n,
  des_round_ctrl_if.slave        host,
  output logic                   ld_data,
  output logic                   key_ld,
  output logic                   round_en,
  output logic [3:0]             round_idx,
  output logic                   key_shift_en,
  output logic                   key_dir,
  output logic [1:0]             key_shift_amt,
  output logic                   fin_en,
  output logic                   busy
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRound = 3'd2,
    StFinal = 3'd3,
    StHold  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rcnt_q  <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rcnt_d         = rcnt_q;
    mode_d         = mode_q;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    ld_data        = 1'b0;
    key_ld         = 1'b0;
    round_en       = 1'b0;
    round_idx      = 4'd0;
    key_shift_en   = 1'b0;
    key_dir        = 1'b0;
    key_shift_amt  = 2'd0;
    fin_en         = 1'b0;

    case (state_q)
      StIdle: begin
        host.in_ready = 1'b1;
        if (host.in_valid) begin
          mode_d  = host.in_decrypt;
          state_d = StLoad;
        end
      end
      StLoad: begin
        ld_data = 1'b1;
        key_ld  = 1'b1;
        rcnt_d  = 4'd0;
        state_d = StRound;
      end
      StRound: begin
        round_en     = 1'b1;
        key_shift_en = 1'b1;
        round_idx    = rcnt_q;
        key_dir      = mode_q;
        // Decrypt round 0 uses K16, which equals the freshly loaded PC1 value.
        if (mode_q && (rcnt_q == 4'd0)) begin
          key_shift_amt = 2'd0;
        end else begin
          key_shift_amt = SHIFT_SCHED[rcnt_q] ? 2'd1 : 2'd2;
        end
        if (rcnt_q == LastRound) begin
          rcnt_d  = 4'd0;
          state_d = StFinal;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      StFinal: begin
        fin_en  = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        host.out_valid = 1'b1;
        if (host.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: accept-relative timing model, directed DES vectors through a
// behavioural datapath, backpressure, mid-round reset, back-to-back and random traffic.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_ctrl_if host ();

  logic       ld_data, key_ld, round_en, key_shift_en, key_dir, fin_en, busy;
  logic [3:0] round_idx;
  logic [1:0] key_shift_amt;

  des_round_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (host),
    .ld_data      (ld_data),
    .key_ld       (key_ld),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .key_shift_en (key_shift_en),
    .key_dir      (key_dir),
    .key_shift_amt(key_shift_amt),
    .fin_en       (fin_en),
    .busy         (busy)
  );

  // ---------------- DES tables ----------------
  localparam int IpTbl [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FpTbl [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int ETbl [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31,
    32, 1};
  localparam int PTbl [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3,
    60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6,
    61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int Pc2Tbl [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
    29, 32};
  // Each S-box row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] SBox [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Key rotation amounts per round, as listed for encrypt and decrypt.
  localparam int EncAmt [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int DecAmt [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IpTbl[i]];
    return r;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-FpTbl[i]];
    return r;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = x[64-Pc1Tbl[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[56-Pc2Tbl[i]];
    return r;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rh, input logic [47:0] k);
    logic [47:0]  e;
    logic [31:0]  s;
    logic [31:0]  r;
    logic [5:0]   b;
    logic [255:0] box;
    int           pos;
    for (int i = 0; i < 48; i++) e[47-i] = rh[32-ETbl[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47-6*j -: 6];
      pos = 16 * int'({b[5], b[0]}) + int'(b[4:1]);
      box = SBox[j];
      s[31-4*j -: 4] = box[255-4*pos -: 4];
    end
    for (int i = 0; i < 32; i++) r[31-i] = s[32-PTbl[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v, input logic dir, input logic [1:0] amt);
    case (amt)
      2'd1:    return dir ? {v[0], v[27:1]}   : {v[26:0], v[27]};
      2'd2:    return dir ? {v[1:0], v[27:2]} : {v[25:0], v[27:26]};
      default: return v;
    endcase
  endfunction

  // ---------------- behavioural datapath driven by the DUT strobes ----------------
  logic [63:0] dp_blk, dp_key, dp_out;
  logic [31:0] dp_l, dp_r;
  logic [27:0] dp_c, dp_d, c_n, d_n;
  logic [47:0] subkey;

  always_comb begin
    c_n    = rot(dp_c, key_dir, key_shift_amt);
    d_n    = rot(dp_d, key_dir, key_shift_amt);
    subkey = pc2_f({c_n, d_n});
  end

  always @(posedge clk) begin
    if (ld_data) {dp_l, dp_r} <= ip_f(dp_blk);
    if (key_ld) {dp_c, dp_d} <= pc1_f(dp_key);
    if (round_en) begin
      dp_c <= c_n;
      dp_d <= d_n;
      dp_l <= dp_r;
      dp_r <= dp_l ^ feistel(dp_r, subkey);
    end
    if (fin_en) dp_out <= fp_f({dp_r, dp_l});
  end

  // ---------------- reference model and checking ----------------
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int age      = -1;  // cycles since the accepting edge; -1 when nothing is in flight
  bit m_mode   = 1'b0;
  int n_acc    = 0;
  int n_loads  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit in_round;
    int amt;
    in_round = (age >= 2) && (age <= 17);
    amt      = 0;
    if (in_round) amt = m_mode ? DecAmt[age-2] : EncAmt[age-2];
    check("in_ready", 64'(host.in_ready), 64'(age < 0));
    check("busy", 64'(busy), 64'(age >= 0));
    check("ld_data", 64'(ld_data), 64'(age == 1));
    check("key_ld", 64'(key_ld), 64'(age == 1));
    check("round_en", 64'(round_en), 64'(in_round));
    check("key_shift_en", 64'(key_shift_en), 64'(in_round));
    check("round_idx", 64'(round_idx), in_round ? 64'(age - 2) : 64'd0);
    check("key_dir", 64'(key_dir), 64'(in_round && m_mode));
    check("key_shift_amt", 64'(key_shift_amt), 64'(amt));
    check("fin_en", 64'(fin_en), 64'(age == 18));
    check("out_valid", 64'(host.out_valid), 64'(age >= 19));
    if (ld_data === 1'b1) n_loads++;
  endtask

  task automatic step(input logic iv, input logic id, input logic ordy, input logic rn);
    host.in_valid   = iv;
    host.in_decrypt = id;
    host.out_ready  = ordy;
    rst_n           = rn;
    if (!rn) begin
      age    = -1;
      m_mode = 1'b0;
    end else if (age < 0) begin
      if (iv) begin
        age    = 1;
        m_mode = id;
        n_acc++;
      end
    end else if (age < 19) begin
      age++;
    end else if (ordy) begin
      age = -1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  initial begin
    int last_ld;
    host.in_valid   = 1'b0;
    host.in_decrypt = 1'b0;
    host.out_ready  = 1'b0;
    rst_n           = 1'b0;
    dp_blk          = 64'h0;
    dp_key          = 64'h0;

    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Known-answer encrypt, result held under backpressure.
    dp_key = 64'h1334_5779_9BBC_DFF1;
    dp_blk = 64'h0123_4567_89AB_CDEF;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (18) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("des_encrypt", dp_out, 64'h85E8_1354_0F0A_B405);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Known-answer decrypt; in_decrypt flips while the block runs.
    dp_blk = 64'h85E8_1354_0F0A_B405;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (18) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    check("des_decrypt", dp_out, 64'h0123_4567_89AB_CDEF);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure with in_valid held throughout: exactly one further accept.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (18) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("bp_out_valid", 64'(host.out_valid), 64'd1);
    check("bp_in_ready", 64'(host.in_ready), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("bp_release_idle", 64'(busy), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("bp_reaccept", 64'(ld_data), 64'd1);
    repeat (18) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset at round 7.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("mid_round_idx", 64'(round_idx), 64'd7);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(host.in_ready), 64'd1);
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Back-to-back: one accept every 20 cycles.
    last_ld = -1;
    repeat (70) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      if (ld_data === 1'b1) begin
        if (last_ld >= 0) check("initiation_interval", 64'(cyc - last_ld), 64'd20);
        last_ld = cyc;
      end
    end

    // Random traffic with occasional resets.
    repeat (1500) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0));
    end

    check("accept_count", 64'(n_loads), 64'(n_acc));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
